// File: rtl/msg_checker.sv
// Scans the decrypted-message RAM and reports whether every byte is
// printable plaintext (a-z or space); pass/done drive key acceptance.
//
// Ports:
//   clk, rst_n  : clock, async active-low reset
//   start       : begin a scan (taken in IDLE and DONE only)
//   addr_dec    : registered read address into the decrypted RAM
//   rddata_dec  : RAM read data, valid RD_LATENCY cycles after addr_dec
//   busy        : scan in progress
//   done        : scan finished, held until next start or reset
//   pass        : 1 when all bytes legal (valid with done)
//   fail_addr   : index of first illegal byte (valid with done, !pass)
module msg_checker #(
    parameter int MSG_LENGTH = 32,
    parameter int RD_LATENCY = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    output logic [7:0] addr_dec,
    input  logic [7:0] rddata_dec,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [7:0] fail_addr
);

    localparam int CW = (RD_LATENCY > 1) ? $clog2(RD_LATENCY) : 1;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT,
        CHECK,
        DONE
    } state_t;

    state_t        state, state_d;
    logic [8:0]    k, k_d, k_inc;
    logic [CW-1:0] cnt, cnt_d;
    logic [7:0]    addr_d, fail_d;
    logic          busy_d, done_d, pass_d;
    logic          legal;

    assign legal = ((rddata_dec >= 8'h61) && (rddata_dec <= 8'h7A))
                 || (rddata_dec == 8'h20);
    assign k_inc = k + 9'd1;

    always_comb begin
        state_d = state;
        k_d     = k;
        cnt_d   = cnt;
        addr_d  = addr_dec;
        busy_d  = busy;
        done_d  = done;
        pass_d  = pass;
        fail_d  = fail_addr;
        unique case (state)
            IDLE, DONE: begin
                // Re-arming from DONE looks exactly like a fresh start.
                if (start) begin
                    state_d = ISSUE;
                    k_d     = 9'd0;
                    addr_d  = 8'd0;
                    busy_d  = 1'b1;
                    done_d  = 1'b0;
                    pass_d  = 1'b0;
                    fail_d  = 8'd0;
                end
            end
            ISSUE: begin
                cnt_d   = CW'(RD_LATENCY - 1);
                state_d = WAIT;
            end
            WAIT: begin
                if (cnt == '0) begin
                    state_d = CHECK;
                end else begin
                    cnt_d = cnt - 1'b1;
                end
            end
            CHECK: begin
                if (!legal) begin
                    state_d = DONE;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    pass_d  = 1'b0;
                    fail_d  = k[7:0];
                    addr_d  = 8'd0;
                end else if (k == 9'(MSG_LENGTH - 1)) begin
                    state_d = DONE;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    pass_d  = 1'b1;
                    fail_d  = 8'd0;
                    addr_d  = 8'd0;
                end else begin
                    state_d = ISSUE;
                    k_d     = k_inc;
                    addr_d  = k_inc[7:0];
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            k         <= 9'd0;
            cnt       <= '0;
            addr_dec  <= 8'd0;
            busy      <= 1'b0;
            done      <= 1'b0;
            pass      <= 1'b0;
            fail_addr <= 8'd0;
        end else begin
            state     <= state_d;
            k         <= k_d;
            cnt       <= cnt_d;
            addr_dec  <= addr_d;
            busy      <= busy_d;
            done      <= done_d;
            pass      <= pass_d;
            fail_addr <= fail_d;
        end
    end

endmodule

// File: tb/tb_msg_checker.sv
// Directed bench for msg_checker: four instances (latency 2/1/3 and a
// 256-byte variant) each reading a shared RAM through a latency pipe.
module tb_msg_checker;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic [3:0] start_v;
    logic [7:0] mem [256];

    logic [7:0] addr_a, rd_a, fa_a;
    logic [7:0] addr_b, rd_b, fa_b;
    logic [7:0] addr_c, rd_c, fa_c;
    logic [7:0] addr_d, rd_d, fa_d;
    logic       busy_a, done_a, pass_a;
    logic       busy_b, done_b, pass_b;
    logic       busy_c, done_c, pass_c;
    logic       busy_d, done_d, pass_d;

    int checks = 0;
    int failures = 0;

    msg_checker #(.MSG_LENGTH(32), .RD_LATENCY(2)) dut_a (
        .clk(clk), .rst_n(rst_n), .start(start_v[0]),
        .addr_dec(addr_a), .rddata_dec(rd_a), .busy(busy_a),
        .done(done_a), .pass(pass_a), .fail_addr(fa_a));
    msg_checker #(.MSG_LENGTH(32), .RD_LATENCY(1)) dut_b (
        .clk(clk), .rst_n(rst_n), .start(start_v[1]),
        .addr_dec(addr_b), .rddata_dec(rd_b), .busy(busy_b),
        .done(done_b), .pass(pass_b), .fail_addr(fa_b));
    msg_checker #(.MSG_LENGTH(32), .RD_LATENCY(3)) dut_c (
        .clk(clk), .rst_n(rst_n), .start(start_v[2]),
        .addr_dec(addr_c), .rddata_dec(rd_c), .busy(busy_c),
        .done(done_c), .pass(pass_c), .fail_addr(fa_c));
    msg_checker #(.MSG_LENGTH(256), .RD_LATENCY(2)) dut_d (
        .clk(clk), .rst_n(rst_n), .start(start_v[3]),
        .addr_dec(addr_d), .rddata_dec(rd_d), .busy(busy_d),
        .done(done_d), .pass(pass_d), .fail_addr(fa_d));

    logic [7:0] pa [2];
    logic [7:0] pb [1];
    logic [7:0] pc [3];
    logic [7:0] pd [2];

    always @(posedge clk) begin
        pa[0] <= mem[addr_a];
        pa[1] <= pa[0];
        pb[0] <= mem[addr_b];
        pc[0] <= mem[addr_c];
        pc[1] <= pc[0];
        pc[2] <= pc[1];
        pd[0] <= mem[addr_d];
        pd[1] <= pd[0];
    end

    assign rd_a = pa[1];
    assign rd_b = pb[0];
    assign rd_c = pc[2];
    assign rd_d = pd[1];

    function automatic logic done_of(input int s);
        case (s)
            0: return done_a;
            1: return done_b;
            2: return done_c;
            default: return done_d;
        endcase
    endfunction

    function automatic logic busy_of(input int s);
        case (s)
            0: return busy_a;
            1: return busy_b;
            2: return busy_c;
            default: return busy_d;
        endcase
    endfunction

    function automatic logic pass_of(input int s);
        case (s)
            0: return pass_a;
            1: return pass_b;
            2: return pass_c;
            default: return pass_d;
        endcase
    endfunction

    function automatic logic [7:0] fa_of(input int s);
        case (s)
            0: return fa_a;
            1: return fa_b;
            2: return fa_c;
            default: return fa_d;
        endcase
    endfunction

    function automatic logic [7:0] addr_of(input int s);
        case (s)
            0: return addr_a;
            1: return addr_b;
            2: return addr_c;
            default: return addr_d;
        endcase
    endfunction

    task automatic fill(input logic [7:0] v);
        for (int i = 0; i < 256; i++) mem[i] = v;
    endtask

    task automatic load_msg();
        string s;
        s = "attack at dawn and hold the gate";
        fill(8'h61);
        for (int i = 0; i < 32; i++) mem[i] = s[i];
    endtask

    // Pulse start for one edge (E0), then wait for done. lat = edges
    // after E0 until done seen (-1 on timeout). 'again' re-pulses start
    // on edge E0+again. done0 = done just after E0.
    task automatic run(input int s, input int bound, input int again,
                       output int lat, output logic [7:0] maxa,
                       output int busy_gap, output logic done0);
        @(negedge clk);
        start_v[s] = 1'b1;
        @(posedge clk);
        #1;
        start_v[s] = 1'b0;
        done0 = done_of(s);
        lat = -1;
        maxa = addr_of(s);
        busy_gap = busy_of(s) ? 0 : 1;
        for (int i = 1; i <= bound; i++) begin
            if (i == again) start_v[s] = 1'b1;
            @(posedge clk);
            #1;
            if (i == again) start_v[s] = 1'b0;
            if (addr_of(s) > maxa) maxa = addr_of(s);
            if (done_of(s)) begin
                lat = i;
                break;
            end
            if (!busy_of(s)) busy_gap++;
        end
    endtask

    int         lat;
    logic [7:0] maxa;
    int         gap;
    logic       d0;

    task automatic test_reset();
        rst_n = 1'b0;
        start_v = 4'd0;
        fill(8'h61);
        #12;
        checks++;
        if ({busy_a, done_a, pass_a, fa_a, addr_a} !== 19'd0) begin
            failures++;
            $display("FAIL reset_a got=%h exp=0",
                     {busy_a, done_a, pass_a, fa_a, addr_a});
        end
        checks++;
        if ({busy_d, done_d, pass_d, fa_d, addr_d} !== 19'd0) begin
            failures++;
            $display("FAIL reset_d got=%h exp=0",
                     {busy_d, done_d, pass_d, fa_d, addr_d});
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({busy_a, done_a} !== 2'b00) begin
            failures++;
            $display("FAIL idle_hold got=%b exp=00", {busy_a, done_a});
        end
    endtask

    task automatic test_full_pass();
        load_msg();
        run(0, 200, -1, lat, maxa, gap, d0);
        checks++;
        if (lat !== 128) begin
            failures++;
            $display("FAIL full_lat got=%0d exp=128", lat);
        end
        checks++;
        if ({pass_a, fa_a} !== {1'b1, 8'd0}) begin
            failures++;
            $display("FAIL full_pass got=%b/%0d exp=1/0", pass_a, fa_a);
        end
        checks++;
        if (gap !== 0) begin
            failures++;
            $display("FAIL full_busy_gap got=%0d exp=0", gap);
        end
        checks++;
        if ({busy_a, addr_a, maxa} !== {1'b0, 8'd0, 8'd31}) begin
            failures++;
            $display("FAIL full_end got=%b/%0d/%0d exp=0/0/31",
                     busy_a, addr_a, maxa);
        end
    endtask

    task automatic test_fail_mid();
        fill(8'h61);
        mem[5] = 8'h41;
        run(0, 200, -1, lat, maxa, gap, d0);
        checks++;
        if (lat !== 24) begin
            failures++;
            $display("FAIL mid_lat got=%0d exp=24", lat);
        end
        checks++;
        if ({pass_a, fa_a} !== {1'b0, 8'd5}) begin
            failures++;
            $display("FAIL mid_result got=%b/%0d exp=0/5", pass_a, fa_a);
        end
        checks++;
        if (maxa !== 8'd5) begin
            failures++;
            $display("FAIL mid_maxaddr got=%0d exp=5", maxa);
        end
    endtask

    task automatic test_boundary();
        logic [7:0] bad [4];
        logic [7:0] good [3];
        bad = '{8'h60, 8'h7B, 8'h1F, 8'h21};
        good = '{8'h61, 8'h7A, 8'h20};
        for (int j = 0; j < 4; j++) begin
            fill(8'h61);
            mem[0] = bad[j];
            run(0, 50, -1, lat, maxa, gap, d0);
            checks++;
            if ({lat, pass_a, fa_a} !== {32'd4, 1'b0, 8'd0}) begin
                failures++;
                $display("FAIL bound_%h got=%0d/%b/%0d exp=4/0/0",
                         bad[j], lat, pass_a, fa_a);
            end
        end
        for (int i = 0; i < 32; i++) mem[i] = good[i % 3];
        run(0, 200, -1, lat, maxa, gap, d0);
        checks++;
        if ({lat, pass_a} !== {32'd128, 1'b1}) begin
            failures++;
            $display("FAIL bound_legal got=%0d/%b exp=128/1", lat, pass_a);
        end
    endtask

    task automatic test_last_byte();
        fill(8'h61);
        mem[31] = 8'hFF;
        run(0, 200, -1, lat, maxa, gap, d0);
        checks++;
        if ({lat, pass_a, fa_a} !== {32'd128, 1'b0, 8'd31}) begin
            failures++;
            $display("FAIL last_byte got=%0d/%b/%0d exp=128/0/31",
                     lat, pass_a, fa_a);
        end
    endtask

    task automatic test_len256();
        for (int i = 0; i < 256; i++)
            mem[i] = (i % 5 == 4) ? 8'h20 : 8'(8'h61 + i % 26);
        run(3, 1100, -1, lat, maxa, gap, d0);
        checks++;
        if ({lat, pass_d, maxa} !== {32'd1024, 1'b1, 8'd255}) begin
            failures++;
            $display("FAIL len256_pass got=%0d/%b/%0d exp=1024/1/255",
                     lat, pass_d, maxa);
        end
        mem[200] = 8'h00;
        run(3, 1100, -1, lat, maxa, gap, d0);
        checks++;
        if ({lat, pass_d, fa_d} !== {32'd804, 1'b0, 8'd200}) begin
            failures++;
            $display("FAIL len256_fail got=%0d/%b/%0d exp=804/0/200",
                     lat, pass_d, fa_d);
        end
    endtask

    task automatic test_latency();
        fill(8'h61);
        run(1, 150, -1, lat, maxa, gap, d0);
        checks++;
        if ({lat, pass_b} !== {32'd96, 1'b1}) begin
            failures++;
            $display("FAIL lat1_pass got=%0d/%b exp=96/1", lat, pass_b);
        end
        mem[5] = 8'h41;
        run(1, 150, -1, lat, maxa, gap, d0);
        checks++;
        if ({lat, pass_b, fa_b} !== {32'd18, 1'b0, 8'd5}) begin
            failures++;
            $display("FAIL lat1_fail got=%0d/%b/%0d exp=18/0/5",
                     lat, pass_b, fa_b);
        end
        run(2, 200, -1, lat, maxa, gap, d0);
        checks++;
        if ({lat, pass_c, fa_c} !== {32'd30, 1'b0, 8'd5}) begin
            failures++;
            $display("FAIL lat3_fail got=%0d/%b/%0d exp=30/0/5",
                     lat, pass_c, fa_c);
        end
        mem[5] = 8'h61;
        run(2, 200, -1, lat, maxa, gap, d0);
        checks++;
        if ({lat, pass_c} !== {32'd160, 1'b1}) begin
            failures++;
            $display("FAIL lat3_pass got=%0d/%b exp=160/1", lat, pass_c);
        end
    endtask

    task automatic test_back_to_back();
        load_msg();
        run(0, 200, 50, lat, maxa, gap, d0);
        checks++;
        if ({lat, pass_a} !== {32'd128, 1'b1}) begin
            failures++;
            $display("FAIL busy_restart got=%0d/%b exp=128/1", lat, pass_a);
        end
        mem[0] = 8'h41;
        run(0, 200, -1, lat, maxa, gap, d0);
        checks++;
        if (d0 !== 1'b0) begin
            failures++;
            $display("FAIL done_drop got=%b exp=0", d0);
        end
        checks++;
        if ({lat, pass_a, fa_a} !== {32'd4, 1'b0, 8'd0}) begin
            failures++;
            $display("FAIL rescan got=%0d/%b/%0d exp=4/0/0",
                     lat, pass_a, fa_a);
        end
    endtask

    task automatic test_reset_mid();
        load_msg();
        @(negedge clk);
        start_v[0] = 1'b1;
        @(posedge clk);
        #1;
        start_v[0] = 1'b0;
        repeat (60) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({busy_a, done_a, pass_a, fa_a, addr_a} !== 19'd0) begin
            failures++;
            $display("FAIL mid_reset got=%h exp=0",
                     {busy_a, done_a, pass_a, fa_a, addr_a});
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        checks++;
        if ({busy_a, done_a, addr_a} !== 10'd0) begin
            failures++;
            $display("FAIL post_reset_idle got=%h exp=0",
                     {busy_a, done_a, addr_a});
        end
        run(0, 200, -1, lat, maxa, gap, d0);
        checks++;
        if ({lat, pass_a} !== {32'd128, 1'b1}) begin
            failures++;
            $display("FAIL post_reset_run got=%0d/%b exp=128/1",
                     lat, pass_a);
        end
    endtask

    initial begin
        test_reset();
        test_full_pass();
        test_fail_mid();
        test_boundary();
        test_last_byte();
        test_len256();
        test_latency();
        test_back_to_back();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
